alu_cmd_sequencer: RTL and testbench

//  Command sequencer for the 8x16 register-file/ALU datapath (reg_alu): accepts LOAD/ALU commands

---
 rtl/alu_cmd_sequencer.sv | 163 ++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//   Command sequencer for the 8x16 register-file/ALU datapath. LOAD/ALU
//   commands arrive over a valid/ready port into a DEPTH-entry FIFO. Each
//   command is then retired in two cycles. In SETUP the datapath controls are
//   stable with wr=0. In COMMIT wr=1 and the datapath writes at the end of the
//   cycle.
// Ports
//   clk, reset (async, active-low)
//   cmd_valid/cmd_ready            command handshake (ready = FIFO not full)
//   cmd_kind, cmd_op, cmd_a, cmd_b, cmd_dst, cmd_imm   command fields
//   sel, wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in   registered datapath controls
//   busy                           FSM active or FIFO non-empty (registered)
//   done                           one-cycle pulse per retired command (registered)
module alu_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_kind,
  input  logic [1:0]    cmd_op,
  input  logic [2:0]    cmd_a,
  input  logic [2:0]    cmd_b,
  input  logic [2:0]    cmd_dst,
  input  logic [DW-1:0] cmd_imm,
  output logic          sel,
  output logic          wr,
  output logic [1:0]    op,
  output logic [2:0]    rd_addr_a,
  output logic [2:0]    rd_addr_b,
  output logic [2:0]    wr_addr,
  output logic [DW-1:0] d_in,
  output logic          busy,
  output logic          done
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int EW = 12 + DW;

  typedef enum logic [1:0] {IDLE, SETUP, COMMIT} state_t;

  state_t state_q, state_d;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_d;
  logic          push, pop;

  logic          hd_kind;
  logic [1:0]    hd_op;
  logic [2:0]    hd_a, hd_b, hd_dst;
  logic [DW-1:0] hd_imm;

  logic          sel_d, wr_d, busy_d, done_d;
  logic [1:0]    op_d;
  logic [2:0]    rd_addr_a_d, rd_addr_b_d, wr_addr_d;
  logic [DW-1:0] d_in_d;

  assign cmd_ready = (count != CW'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign {hd_kind, hd_op, hd_a, hd_b, hd_dst, hd_imm} = mem[rd_ptr];
  assign count_d   = count + CW'(push) - CW'(pop);

  // FIFO storage carries data only; it is not reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_kind, cmd_op, cmd_a, cmd_b, cmd_dst, cmd_imm};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_d;
    end
  end

  // Next-state and next-output decode. Controls hold their value unless a
  // command is loaded. LOAD leaves op/rd_addr alone and ALU leaves d_in alone.
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    sel_d       = sel;
    wr_d        = 1'b0;
    op_d        = op;
    rd_addr_a_d = rd_addr_a;
    rd_addr_b_d = rd_addr_b;
    wr_addr_d   = wr_addr;
    d_in_d      = d_in;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        wr_d    = 1'b1;
        state_d = COMMIT;
      end
      COMMIT: begin
        done_d = 1'b1;
        if (count != '0) begin
          pop     = 1'b1;
          state_d = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      wr_addr_d = hd_dst;
      if (hd_kind) begin
        sel_d       = 1'b1;
        op_d        = hd_op;
        rd_addr_a_d = hd_a;
        rd_addr_b_d = hd_b;
      end else begin
        sel_d  = 1'b0;
        d_in_d = hd_imm;
      end
    end

    busy_d = (state_d != IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      sel       <= 1'b0;
      wr        <= 1'b0;
      op        <= '0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      wr_addr   <= '0;
      d_in      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel       <= sel_d;
      wr        <= wr_d;
      op        <= op_d;
      rd_addr_a <= rd_addr_a_d;
      rd_addr_b <= rd_addr_b_d;
      wr_addr   <= wr_addr_d;
      d_in      <= d_in_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer
//   Directed and randomized stimulus for alu_cmd_sequencer. It keeps two
//   models of the register file. The golden model applies each command
//   arithmetically in issue order. The datapath model applies whatever the
//   DUT's wr/sel/op/address controls say. Each wr pulse is checked against the
//   oldest outstanding command. At the end, both models must agree.
module tb_alu_cmd_sequencer;
  localparam int DEPTH = 4;
  localparam int DW    = 16;

  typedef struct packed {
    logic          kind;
    logic [1:0]    op;
    logic [2:0]    a;
    logic [2:0]    b;
    logic [2:0]    dst;
    logic [DW-1:0] imm;
  } cmd_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_kind;
  logic [1:0]    cmd_op;
  logic [2:0]    cmd_a, cmd_b, cmd_dst;
  logic [DW-1:0] cmd_imm;
  logic          sel, wr, busy, done;
  logic [1:0]    op;
  logic [2:0]    rd_addr_a, rd_addr_b, wr_addr;
  logic [DW-1:0] d_in;

  alu_cmd_sequencer #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_dst(cmd_dst), .cmd_imm(cmd_imm),
    .sel(sel), .wr(wr), .op(op), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .wr_addr(wr_addr), .d_in(d_in), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  cmd_t          cmds [512];
  int            n_iss = 0;
  int            n_ret = 0;
  logic [DW-1:0] gold [8];
  logic [DW-1:0] dp   [8];
  int            wr_cnt = 0;
  int            done_cnt = 0;
  int            wt [1024];
  logic          prev_wr = 1'b0;
  logic          stall_seen;
  cmd_t          mc;

  function automatic logic [DW-1:0] alu_f(input logic [1:0] f, input logic [DW-1:0] x,
                                          input logic [DW-1:0] y);
    case (f)
      2'd0:    return x + y;
      2'd1:    return x - y;
      2'd2:    return x & y;
      default: return x ^ y;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Datapath model plus scoreboard. It samples on the falling edge, and a
  // write seen in COMMIT lands at the end of that cycle.
  always @(negedge clk) begin
    if (reset) begin
      if (wr) begin
        check("wr_not_consecutive", 32'(prev_wr), 32'd0);
        check("wr_has_pending_cmd", 32'(n_ret < n_iss), 32'd1);
        if (n_ret < n_iss) begin
          mc = cmds[n_ret % 512];
          n_ret <= n_ret + 1;
          check("wr_addr", 32'(wr_addr), 32'(mc.dst));
          check("sel", 32'(sel), 32'(mc.kind));
          if (mc.kind) begin
            check("op", 32'(op), 32'(mc.op));
            check("rd_addr_a", 32'(rd_addr_a), 32'(mc.a));
            check("rd_addr_b", 32'(rd_addr_b), 32'(mc.b));
          end else begin
            check("d_in", 32'(d_in), 32'(mc.imm));
          end
        end
        dp[wr_addr] <= sel ? alu_f(op, dp[rd_addr_a], dp[rd_addr_b]) : d_in;
        wt[wr_cnt % 1024] <= cyc;
        wr_cnt <= wr_cnt + 1;
      end
      if (done) done_cnt <= done_cnt + 1;
      prev_wr <= wr;
    end else begin
      prev_wr <= 1'b0;
    end
  end

  function automatic cmd_t mk(input logic kind, input logic [1:0] f, input logic [2:0] a,
                              input logic [2:0] b, input logic [2:0] dst, input logic [DW-1:0] imm);
    cmd_t c;
    c.kind = kind; c.op = f; c.a = a; c.b = b; c.dst = dst; c.imm = imm;
    return c;
  endfunction

  function automatic cmd_t rnd_cmd();
    return mk(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
              3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), DW'($urandom));
  endfunction

  // Called just after a rising edge. Returns just after the edge that accepted c.
  task automatic send(input cmd_t c);
    int g;
    cmd_valid = 1'b1;
    cmd_kind = c.kind; cmd_op = c.op; cmd_a = c.a; cmd_b = c.b;
    cmd_dst = c.dst; cmd_imm = c.imm;
    g = 0;
    while (!cmd_ready && g < 100) begin
      stall_seen = 1'b1;
      @(posedge clk); #1;
      g++;
    end
    if (!cmd_ready) check("ready_timeout", 32'(cmd_ready), 32'd1);
    cmds[n_iss % 512] = c;
    n_iss++;
    gold[c.dst] = c.kind ? alu_f(c.op, gold[c.a], gold[c.b]) : c.imm;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy && n_ret == n_iss) break;
    end
    check("idle_reached", 32'(!busy && n_ret == n_iss), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, d0;
    for (int i = 0; i < 8; i++) begin
      gold[i] = '0;
      dp[i]   = '0;
    end
    reset = 1'b0; cmd_valid = 1'b0; cmd_kind = 1'b0; cmd_op = '0;
    cmd_a = '0; cmd_b = '0; cmd_dst = '0; cmd_imm = '0;
    stall_seen = 1'b0;

    // Reset state
    #12;
    check("rst_wr", 32'(wr), 32'd0);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_ctrl", 32'({op, rd_addr_a, rd_addr_b, wr_addr, d_in}), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    idle_cycles(2);

    // Test 1: LOAD r1=5, LOAD r2=3, ADD r3=r1+r2
    w0 = wr_cnt; d0 = done_cnt;
    send(mk(1'b0, 2'd0, 3'd0, 3'd0, 3'd1, 16'd5));
    send(mk(1'b0, 2'd0, 3'd0, 3'd0, 3'd2, 16'd3));
    send(mk(1'b1, 2'd0, 3'd1, 3'd2, 3'd3, 16'd0));
    wait_idle();
    check("t1_wr_pulses", 32'(wr_cnt - w0), 32'd3);
    check("t1_done_pulses", 32'(done_cnt - d0), 32'd3);
    check("t1_spacing_01", 32'(wt[(w0 + 1) % 1024] - wt[w0 % 1024]), 32'd2);
    check("t1_spacing_12", 32'(wt[(w0 + 2) % 1024] - wt[(w0 + 1) % 1024]), 32'd2);
    check("t1_r3", 32'(dp[3]), 32'd8);

    // Test 2: single LOAD latency. The accepting edge is k, and send returns inside cycle k.
    send(mk(1'b0, 2'd0, 3'd0, 3'd0, 3'd7, 16'hBEEF));
    @(negedge clk); check("t2_wr_k", 32'(wr), 32'd0);
    @(negedge clk); check("t2_wr_k1", 32'(wr), 32'd0);
    @(negedge clk); check("t2_wr_k2", 32'(wr), 32'd1);
    check("t2_addr", 32'(wr_addr), 32'd7);
    check("t2_data", 32'(d_in), 32'hBEEF);
    @(negedge clk); check("t2_wr_k3", 32'(wr), 32'd0);
    check("t2_done_k3", 32'(done), 32'd1);
    @(negedge clk); check("t2_done_k4", 32'(done), 32'd0);
    check("t2_busy_after", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // Test 3: flood faster than retire rate so the FIFO fills and ready drops
    stall_seen = 1'b0;
    for (int i = 0; i < 12; i++) send(rnd_cmd());
    check("t3_ready_dropped", 32'(stall_seen), 32'd1);
    wait_idle();
    check("t3_ready_after", 32'(cmd_ready), 32'd1);

    // Test 6: dst equals source A, so the result uses the pre-write r4
    send(mk(1'b0, 2'd0, 3'd0, 3'd0, 3'd4, 16'd10));
    send(mk(1'b0, 2'd0, 3'd0, 3'd0, 3'd5, 16'd7));
    send(mk(1'b1, 2'd1, 3'd4, 3'd5, 3'd4, 16'd0));
    wait_idle();
    check("t6_r4", 32'(dp[4]), 32'd3);

    // Randomized traffic with random gaps
    for (int i = 0; i < 40; i++) begin
      send(rnd_cmd());
      idle_cycles($urandom_range(0, 2));
    end
    wait_idle();
    for (int i = 0; i < 8; i++) check($sformatf("rf_r%0d", i), 32'(dp[i]), 32'(gold[i]));
    check("retired_all", 32'(n_ret), 32'(n_iss));

    // Test 5: reset during COMMIT of the first of three, with two still queued
    send(mk(1'b0, 2'd0, 3'd0, 3'd0, 3'd1, 16'h1111));
    send(mk(1'b0, 2'd0, 3'd0, 3'd0, 3'd2, 16'h2222));
    send(mk(1'b0, 2'd0, 3'd0, 3'd0, 3'd3, 16'h3333));
    check("t5_in_commit", 32'(wr), 32'd1);
    reset = 1'b0;
    #1;
    check("t5_wr_drop", 32'(wr), 32'd0);
    check("t5_done_drop", 32'(done), 32'd0);
    check("t5_busy_drop", 32'(busy), 32'd0);
    check("t5_ready", 32'(cmd_ready), 32'd1);
    n_iss = n_ret;
    for (int i = 0; i < 8; i++) gold[i] = dp[i];
    idle_cycles(2);
    reset = 1'b1;
    w0 = wr_cnt; d0 = done_cnt;
    idle_cycles(12);
    check("t5_no_wr_after", 32'(wr_cnt - w0), 32'd0);
    check("t5_no_done_after", 32'(done_cnt - d0), 32'd0);
    check("t5_busy_after", 32'(busy), 32'd0);
    check("t5_ready_after", 32'(cmd_ready), 32'd1);

    // Sequencer still works after reset
    send(mk(1'b0, 2'd0, 3'd0, 3'd0, 3'd6, 16'h00A5));
    send(mk(1'b1, 2'd3, 3'd6, 3'd1, 3'd0, 16'd0));
    wait_idle();
    for (int i = 0; i < 8; i++) check($sformatf("post_rst_r%0d", i), 32'(dp[i]), 32'(gold[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
